argo_pipe_arbiter: RTL and testbench

//  Shares one argo_3stage pipeline among N requester go-routines (channel writers).

---
 rtl/argo_pipe_arbiter_pkg.sv | 18 +
 rtl/argo_tag_fifo.sv | 83 ++++++++
 rtl/argo_pipe_arbiter.sv | 118 +++++++++++
 tb/tb_argo_pipe_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/argo_pipe_arbiter_pkg.sv
// Shared constants and sizing helpers for the argo pipeline arbiter.
package argo_pipe_arbiter_pkg;

  localparam int ARGO_N_REQ     = 4;
  localparam int ARGO_DATA_W    = 32;
  localparam int ARGO_TAG_DEPTH = 8;

  // Width of a requester tag; never narrower than one bit.
  function automatic int argo_tag_w(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  // Width of an occupancy counter that can hold the full depth value.
  function automatic int argo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/argo_tag_fifo.sv
// In-order FIFO of requester tags for words currently inside the pipeline.
// A push is refused whenever the FIFO is full, even if a pop happens in the
// same cycle, so the count can never exceed DEPTH.
module argo_tag_fifo
  import argo_pipe_arbiter_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8,
  parameter int CNT_W = argo_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] head_tag_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == {CNT_W{1'b0}});
  assign do_push_s  = push_i && !full_o;
  assign do_pop_s   = pop_i && !empty_o;
  assign head_tag_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Next-state pointers (natural wrap, DEPTH is a power of two) and count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards every tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage, written at the tail on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

endmodule

// File: rtl/argo_pipe_arbiter.sv
// Shares one pipeline among N_REQ requesters: round-robin issue with a tag
// per accepted word, and in-order return routing to the owning responder.
module argo_pipe_arbiter
  import argo_pipe_arbiter_pkg::*;
#(
  parameter int N_REQ     = ARGO_N_REQ,
  parameter int DATA_W    = ARGO_DATA_W,
  parameter int TAG_DEPTH = ARGO_TAG_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      pipe_ovalid,
  output logic [DATA_W-1:0]         pipe_odata,
  input  logic                      pipe_iready,
  input  logic                      pipe_ivalid,
  input  logic [DATA_W-1:0]         pipe_idata,
  output logic                      pipe_oready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [$clog2(TAG_DEPTH):0] inflight,
  output logic                      err_untagged
);

  localparam int TW = argo_tag_w(N_REQ);
  localparam int CW = argo_cnt_w(TAG_DEPTH);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0] winner_s, cand_s, head_s;
  logic          found_s, any_req_s;
  logic          tag_full_s, tag_empty_s;
  logic          push_s, pop_s;
  logic          err_q, err_d;
  logic [CW-1:0] count_s;

  assign any_req_s = |req_valid;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    winner_s = '0;
    cand_s   = '0;
    found_s  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = TW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found_s && req_valid[cand_s]) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Issue side: everything is held low while reset is asserted.
  assign pipe_ovalid = rst && any_req_s && !tag_full_s;
  assign pipe_odata  = req_data[int'(winner_s)*DATA_W +: DATA_W];
  assign req_ready   = (rst && any_req_s && pipe_iready && !tag_full_s) ?
                       (ONE_HOT0 << winner_s) : {N_REQ{1'b0}};
  assign push_s      = pipe_ovalid && pipe_iready;

  // Return side: the head tag selects which responder sees the word.
  assign rsp_valid   = (rst && pipe_ivalid && !tag_empty_s) ?
                       (ONE_HOT0 << head_s) : {N_REQ{1'b0}};
  assign pipe_oready = rst && !tag_empty_s && rsp_ready[head_s];
  assign rsp_data    = pipe_idata;
  assign pop_s       = pipe_oready && pipe_ivalid;

  assign inflight     = count_s;
  assign err_untagged = err_q;

  // Pointer moves only on an accepted word; error is sticky until reset.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    if (push_s) begin
      rr_ptr_d = winner_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    if (pipe_ivalid && tag_empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Round-robin pointer (port 0 wins first after reset) and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= TW'(N_REQ - 1);
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  argo_tag_fifo #(
    .TAG_W (TW),
    .DEPTH (TAG_DEPTH),
    .CNT_W (CW)
  ) u_tag_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (push_s),
    .push_tag_i (winner_s),
    .pop_i      (pop_s),
    .head_tag_o (head_s),
    .full_o     (tag_full_s),
    .empty_o    (tag_empty_s),
    .count_o    (count_s)
  );

endmodule

// File: tb/tb_argo_pipe_arbiter.sv
// Randomized bench for argo_pipe_arbiter with a 3-cycle pipeline model behind it.
module tb_argo_pipe_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int TD   = 8;
  localparam int PLAT = 3;

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data;
  logic            pipe_ovalid, pipe_iready, pipe_ivalid, pipe_oready, err_untagged;
  logic [DW-1:0]   pipe_odata, pipe_idata, rsp_data;
  logic [3:0]      inflight;

  argo_pipe_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pipe_ovalid(pipe_ovalid), .pipe_odata(pipe_odata),
    .pipe_iready(pipe_iready), .pipe_ivalid(pipe_ivalid), .pipe_idata(pipe_idata),
    .pipe_oready(pipe_oready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .inflight(inflight), .err_untagged(err_untagged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Environment: requesters, sinks and pipeline
  bit [N-1:0]    hold_v;
  logic [DW-1:0] hold_d [N];
  logic [DW-1:0] dir2 [$];
  bit            use_dir, block1, force_iv;
  bit [N-1:0]    req_mask;
  int            p_req, p_rsp, p_stall;
  logic [DW-1:0] pq_d [$];
  int            pq_t [$];
  int            cyc;
  int            dut_rcv [N];
  logic [N-1:0]  last_rdy;

  // Reference model: tag order, per-port expected words, last granted port
  int            tq [$];
  logic [DW-1:0] exp_q [N][$];
  int            last_g;
  bit            err_m;

  task automatic model_reset();
    tq.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    last_g = N - 1;
    err_m  = 1'b0;
    pq_d.delete();
    pq_t.delete();
  endtask

  task automatic clear_rcv();
    for (int i = 0; i < N; i++) dut_rcv[i] = 0;
  endtask

  task automatic step();
    int win, p;
    bit full_m, any_m, exp_ov, exp_or, in_x, out_x, pre_empty;
    logic [N-1:0] exp_rdy, exp_rv, rdy_c, rv_c, rr_c, rqv_c;
    logic ov_c, or_c;
    logic [DW-1:0] od_c;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!hold_v[i] && req_mask[i]) begin
        if (i == 2 && use_dir) begin
          if (dir2.size() > 0) begin hold_v[i] = 1'b1; hold_d[i] = dir2.pop_front(); end
        end else if ($urandom_range(99) < p_req) begin
          hold_v[i] = 1'b1;
          hold_d[i] = $urandom;
        end
      end
      req_valid[i] = hold_v[i];
      req_data[i*DW +: DW] = hold_d[i];
      rsp_ready[i] = ($urandom_range(99) < p_rsp) && !(i == 1 && block1);
    end
    pipe_iready = ($urandom_range(99) >= p_stall) && (pq_d.size() < 16);
    if (force_iv) begin
      pipe_ivalid = 1'b1; pipe_idata = 32'hdeadbeef;
    end else if (pq_d.size() > 0 && pq_t[0] <= cyc) begin
      pipe_ivalid = 1'b1; pipe_idata = pq_d[0];
    end else begin
      pipe_ivalid = 1'b0; pipe_idata = 32'h0;
    end
    #1;
    full_m = (tq.size() == TD);
    any_m  = |req_valid;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      int idx = (last_g + k) % N;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    exp_ov  = any_m && !full_m;
    exp_rdy = '0;
    if (exp_ov && pipe_iready) exp_rdy[win] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    check("pipe_ovalid", pipe_ovalid, exp_ov);
    if (exp_ov) check("pipe_odata", pipe_odata, hold_d[win]);
    pre_empty = (tq.size() == 0);
    exp_rv = '0;
    exp_or = 1'b0;
    if (!pre_empty) begin
      if (pipe_ivalid) exp_rv[tq[0]] = 1'b1;
      exp_or = rsp_ready[tq[0]];
    end
    check("rsp_valid", rsp_valid, exp_rv);
    check("pipe_oready", pipe_oready, exp_or);
    in_x  = exp_ov && pipe_iready;
    out_x = exp_or && pipe_ivalid;
    rdy_c = req_ready; rqv_c = req_valid; rv_c = rsp_valid; rr_c = rsp_ready;
    ov_c = pipe_ovalid; or_c = pipe_oready; od_c = pipe_odata;
    last_rdy = req_ready;
    @(posedge clk);
    if (pipe_ivalid && pre_empty) err_m = 1'b1;
    if (out_x) begin
      p = tq.pop_front();
      check("rsp_order", pipe_idata, exp_q[p].pop_front());
    end
    if (in_x) begin
      tq.push_back(win);
      exp_q[win].push_back(hold_d[win]);
      last_g = win;
    end
    for (int i = 0; i < N; i++) begin
      if (rqv_c[i] && rdy_c[i]) hold_v[i] = 1'b0;
      if (rv_c[i] && rr_c[i]) dut_rcv[i]++;
    end
    if (ov_c && pipe_iready) begin pq_d.push_back(od_c); pq_t.push_back(cyc + PLAT); end
    if (or_c && pipe_ivalid && !force_iv) begin void'(pq_d.pop_front()); void'(pq_t.pop_front()); end
    cyc++;
    #1;
    check("inflight", inflight, tq.size());
    check("err_untagged", err_untagged, err_m);
  endtask

  task automatic set_mode(input int pr, input int ps, input int st);
    p_req = pr; p_rsp = ps; p_stall = st;
  endtask

  task automatic drain();
    set_mode(0, 100, 0);
    block1 = 1'b0; force_iv = 1'b0;
    repeat (25) step();
  endtask

  int saved, total, diff;

  initial begin
    rst = 1'b0;
    cyc = 0; hold_v = '0; use_dir = 1'b0; block1 = 1'b0; force_iv = 1'b0;
    req_mask = '1; last_rdy = '0;
    for (int i = 0; i < N; i++) hold_d[i] = '0;
    model_reset(); clear_rcv();
    req_valid = '1; req_data = '0; rsp_ready = '1;
    pipe_iready = 1'b1; pipe_ivalid = 1'b1; pipe_idata = '0;
    #2;
    // Reset state: outputs suppressed even with all inputs asserted
    check("rst_inflight", inflight, 0);
    check("rst_err", err_untagged, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ovalid", pipe_ovalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_oready", pipe_oready, 0);
    req_valid = '0; pipe_ivalid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;

    // 1. Single requester, port 2 with fixed words
    use_dir = 1'b1; req_mask = 4'b0100;
    dir2.push_back(32'h25); dir2.push_back(32'h55); dir2.push_back(32'h19700328);
    set_mode(100, 100, 0);
    clear_rcv();
    repeat (15) step();
    check("t1_count2", dut_rcv[2], 3);
    check("t1_others", dut_rcv[0] + dut_rcv[1] + dut_rcv[3], 0);
    use_dir = 1'b0; req_mask = '1;

    // 2. Fairness with everything valid and ready
    drain();
    clear_rcv();
    set_mode(100, 100, 0);
    repeat (100) step();
    total = 0;
    for (int i = 0; i < N; i++) total += dut_rcv[i];
    for (int i = 0; i < N; i++) begin
      diff = dut_rcv[i] - total / N;
      if (diff < 0) diff = -diff;
      check($sformatf("fair_p%0d", i), (diff <= 1), 1);
    end

    // 3. Back-pressure on responder 1
    drain();
    set_mode(100, 100, 0);
    block1 = 1'b1;
    repeat (20) step();
    check("bp_inflight", inflight, TD);
    check("bp_req_ready", req_ready, 0);
    check("bp_oready", pipe_oready, 0);
    block1 = 1'b0;
    repeat (40) step();

    // 4. Pipeline stall keeps tags and pointer
    drain();
    set_mode(100, 0, 100);
    saved = tq.size();
    repeat (5) begin
      step();
      check("stall_inflight", inflight, saved);
    end
    set_mode(100, 100, 0);
    repeat (10) step();

    // 5. Asynchronous reset with five words in flight
    drain();
    set_mode(100, 0, 0);
    for (int n = 0; n < 50 && tq.size() != 5; n++) step();
    check("t5_reach", inflight, 5);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("t5_inflight", inflight, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_req_ready", req_ready, 0);
    check("t5_ovalid", pipe_ovalid, 0);
    repeat (2) @(negedge clk);
    hold_v = '1;
    @(posedge clk); #3 rst = 1'b1;
    set_mode(100, 100, 0);
    step();
    check("t5_first_grant", last_rdy, 4'b0001);
    repeat (10) step();

    // 6. Untagged pipeline output
    drain();
    set_mode(0, 100, 0);
    force_iv = 1'b1;
    step();
    check("t6_err_set", err_untagged, 1);
    force_iv = 1'b0;
    repeat (3) step();
    check("t6_err_sticky", err_untagged, 1);
    #2 rst = 1'b0;
    model_reset();
    #1 check("t6_err_clear", err_untagged, 0);
    @(posedge clk); #3 rst = 1'b1;

    // Random traffic
    set_mode(60, 70, 20);
    repeat (600) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
